// File: rtl/keypad_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_event_fifo
//  Description : Buffers key codes from the slow keypad scanner for the
//                PicoBlaze. key_valid is synchronised and rising-edge
//                detected. Each press queues one 4-bit code and raises an
//                interrupt. A data-port read pops the head entry. A
//                status-port read clears the sticky overflow flag.
//  Ports       : clk             - system clock, rising edge
//                rst             - asynchronous active-high reset
//                i_key_valid     - scanner press flag (asynchronous to clk)
//                i_key_code      - scanner key code (4 bits)
//                i_port_id       - processor port address
//                i_read_strobe   - processor read qualifier
//                i_interrupt_ack - processor interrupt acknowledge
//                o_data_out      - combinational read data for input mux
//                o_interrupt     - registered interrupt request
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_event_fifo #(
  parameter int         DEPTH_LOG2  = 3,
  parameter logic [7:0] PORT_DATA   = 8'h01,
  parameter logic [7:0] PORT_STATUS = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_code,
  input  logic [7:0] i_port_id,
  input  logic       i_read_strobe,
  input  logic       i_interrupt_ack,
  output logic [7:0] o_data_out,
  output logic       o_interrupt
);

  localparam int              c_CW    = DEPTH_LOG2 + 1;
  localparam int              c_NENT  = 1 << DEPTH_LOG2;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(c_NENT);

  // Synchroniser chain for the press flag, plus a two-stage code pipeline
  // that keeps the code aligned with the detected edge.
  logic            r_s1, r_s2, r_s3;
  logic [3:0]      r_c1, r_c2;

  logic [3:0]           r_mem [0:c_NENT-1];
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0]      r_count;
  logic                 r_overflow;
  logic                 r_interrupt;

  logic w_push_req, w_full, w_empty, w_pop, w_push_ok, w_drop, w_status_rd;
  logic [3:0] w_head;
  logic [4:0] w_count5;

  assign w_push_req  = r_s2 & ~r_s3;
  assign w_full      = (r_count == c_DEPTH);
  assign w_empty     = (r_count == '0);
  assign w_pop       = i_read_strobe & (i_port_id == PORT_DATA) & ~w_empty;
  assign w_status_rd = i_read_strobe & (i_port_id == PORT_STATUS);
  // A pop on the same edge frees a slot, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_push_ok   = w_push_req & (~w_full | w_pop);
  assign w_drop      = w_push_req & w_full & ~w_pop;
  assign w_head      = w_empty ? 4'h0 : r_mem[r_rd_ptr];
  assign w_count5    = 5'(r_count);

  // Sync flops reset high so a key already held at reset release is not
  // mistaken for a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
      r_c1 <= 4'h0;
      r_c2 <= 4'h0;
    end else begin
      r_s1 <= i_key_valid;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_c1 <= i_key_code;
      r_c2 <= r_c1;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= r_c2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (w_pop && !w_push_ok) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  // Overflow is sticky; a drop on the clearing edge still wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (w_status_rd) begin
      r_overflow <= 1'b0;
    end
  end

  // Only new accepted pushes raise the interrupt; leftover entries do not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_interrupt <= 1'b0;
    end else if (w_push_ok) begin
      r_interrupt <= 1'b1;
    end else if (i_interrupt_ack) begin
      r_interrupt <= 1'b0;
    end
  end

  always_comb begin
    o_data_out = 8'h00;
    if (i_port_id == PORT_DATA) begin
      o_data_out = {r_overflow, ~w_empty, 2'b00, w_head};
    end else if (i_port_id == PORT_STATUS) begin
      o_data_out = {r_overflow, w_full, w_empty, w_count5};
    end
  end

  assign o_interrupt = r_interrupt;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_event_fifo
//  Description : Self-checking bench for keypad_event_fifo. A queue-based
//                model predicts interrupt and read data every cycle; directed
//                scenarios also check hand-computed literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_event_fifo;

  localparam logic [7:0] c_PD    = 8'h01;
  localparam logic [7:0] c_PS    = 8'h02;
  localparam int         c_DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_key_valid = 1'b0;
  logic [3:0] i_key_code = 4'h0;
  logic [7:0] i_port_id = 8'h00;
  logic       i_read_strobe = 1'b0;
  logic       i_interrupt_ack = 1'b0;
  logic [7:0] o_data_out;
  logic       o_interrupt;

  int n_checks = 0;
  int n_errors = 0;

  keypad_event_fifo #(
    .DEPTH_LOG2 (3),
    .PORT_DATA  (c_PD),
    .PORT_STATUS(c_PS)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_key_valid    (i_key_valid),
    .i_key_code     (i_key_code),
    .i_port_id      (i_port_id),
    .i_read_strobe  (i_read_strobe),
    .i_interrupt_ack(i_interrupt_ack),
    .o_data_out     (o_data_out),
    .o_interrupt    (o_interrupt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A press raised by the stimulus is scheduled to land as a push on the
  // third rising edge after key_valid goes high.
  logic [3:0] m_q[$];
  bit         m_ovf = 1'b0;
  bit         m_irq = 1'b0;
  int         m_edge = 0;
  bit         m_sched_vld = 1'b0;
  int         m_sched_edge = 0;
  logic [3:0] m_sched_code = 4'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_irq = 1'b0;
      m_sched_vld = 1'b0;
    end else begin
      bit push, pop, acc;
      m_edge = m_edge + 1;
      push = m_sched_vld && (m_sched_edge == m_edge);
      if (push) m_sched_vld = 1'b0;
      pop = i_read_strobe && (i_port_id == c_PD) && (m_q.size() != 0);
      if (i_read_strobe && (i_port_id == c_PS)) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      acc = 1'b0;
      if (push) begin
        if (m_q.size() < c_DEPTH) begin
          m_q.push_back(m_sched_code);
          acc = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (acc) m_irq = 1'b1;
      else if (i_interrupt_ack) m_irq = 1'b0;
    end
  end

  function automatic logic [7:0] exp_data(input logic [7:0] pid);
    int n;
    n = m_q.size();
    if (pid == c_PD)
      return {m_ovf, (n != 0), 2'b00, (n != 0) ? m_q[0] : 4'h0};
    else if (pid == c_PS)
      return {m_ovf, (n == c_DEPTH), (n == 0), 5'(n)};
    else
      return 8'h00;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_irq", {7'd0, o_interrupt}, {7'd0, m_irq});
      check("model_dout", o_data_out, exp_data(i_port_id));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One press; optionally a data pop and/or an ack land on the push edge.
  task automatic press(input logic [3:0] code, input bit pop_e3, input bit ack_e3);
    i_key_code = code;
    step(2);
    i_key_valid  = 1'b1;
    m_sched_code = code;
    m_sched_edge = m_edge + 3;
    m_sched_vld  = 1'b1;
    step(2);
    if (pop_e3) begin
      i_port_id = c_PD;
      i_read_strobe = 1'b1;
    end
    if (ack_e3) i_interrupt_ack = 1'b1;
    step(1);
    i_read_strobe = 1'b0;
    i_interrupt_ack = 1'b0;
    i_key_valid = 1'b0;
    step(3);
  endtask

  // Strobed read: checks the combinational value seen before the edge.
  task automatic rd(input string name, input logic [7:0] pid, input logic [7:0] exp);
    i_port_id = pid;
    i_read_strobe = 1'b1;
    #1;
    check(name, o_data_out, exp);
    step(1);
    i_read_strobe = 1'b0;
  endtask

  // Non-strobed peek.
  task automatic peek(input string name, input logic [7:0] pid, input logic [7:0] exp);
    i_port_id = pid;
    #1;
    check(name, o_data_out, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    check("reset_irq", {7'd0, o_interrupt}, 8'h00);
    peek("reset_status", c_PS, 8'h20);

    // 1: single press
    press(4'hA, 1'b0, 1'b0);
    check("t1_irq", {7'd0, o_interrupt}, 8'h01);
    peek("t1_status", c_PS, 8'h01);
    rd("t1_data", c_PD, 8'h4A);
    peek("t1_status_after", c_PS, 8'h20);
    peek("t1_data_empty", c_PD, 8'h00);
    peek("t1_other_port", 8'h7F, 8'h00);

    // 2: overflow with nine presses
    for (int k = 0; k < 9; k++) press(4'(k), 1'b0, 1'b0);
    peek("t2_status_full", c_PS, 8'hC8);
    rd("t2_first_pop", c_PD, 8'hC0);
    rd("t2_status_clear", c_PS, 8'h87);
    for (int k = 1; k < 8; k++) rd("t2_drain", c_PD, 8'h40 + 8'(k));
    peek("t2_status_empty", c_PS, 8'h20);
    rd("t2_pop_empty", c_PD, 8'h00);

    // 3: push and pop on the same edge while full
    for (int k = 1; k <= 8; k++) press(4'(k), 1'b0, 1'b0);
    peek("t3_head_before", c_PD, 8'h41);
    press(4'h9, 1'b1, 1'b0);
    peek("t3_status", c_PS, 8'h48);
    for (int k = 2; k <= 9; k++) rd("t3_drain", c_PD, 8'h40 + 8'(k));
    peek("t3_empty", c_PS, 8'h20);

    // 4: key held across reset release
    i_key_valid = 1'b1;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    check("t4_irq_held", {7'd0, o_interrupt}, 8'h00);
    peek("t4_status_held", c_PS, 8'h20);
    i_key_valid = 1'b0;
    step(4);
    press(4'h3, 1'b0, 1'b0);
    peek("t4_status_one", c_PS, 8'h01);
    rd("t4_data", c_PD, 8'h43);

    // 5: ack coincides with accepted push
    i_interrupt_ack = 1'b1;
    step(1);
    i_interrupt_ack = 1'b0;
    check("t5_irq_pre", {7'd0, o_interrupt}, 8'h00);
    press(4'h5, 1'b0, 1'b1);
    check("t5_irq_kept", {7'd0, o_interrupt}, 8'h01);
    i_interrupt_ack = 1'b1;
    step(1);
    i_interrupt_ack = 1'b0;
    check("t5_irq_cleared", {7'd0, o_interrupt}, 8'h00);
    rd("t5_data", c_PD, 8'h45);

    // 6: asynchronous reset mid-stream
    press(4'h6, 1'b0, 1'b0);
    press(4'h7, 1'b0, 1'b0);
    press(4'h8, 1'b0, 1'b0);
    peek("t6_status_three", c_PS, 8'h03);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t6_irq_in_rst", {7'd0, o_interrupt}, 8'h00);
    check("t6_status_in_rst", o_data_out, 8'h20);
    #1;
    rst = 1'b0;
    #1;
    check("t6_status_after", o_data_out, 8'h20);
    step(3);
    peek("t6_data_empty", c_PD, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
